// File: rtl/panel_loader.sv
// Byte-stream to LED-panel pixel writer: parses {ADDR_HI, ADDR_LO, (R,G,B)*} packets
// and emits one registered pixel write per complete RGB triple into a DEPTH-deep buffer.
module panel_loader #(
  parameter int CHAINED = 3,
  parameter int ADDR_W  = 16
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              ctrl_en,
  output logic [3:0]        ctrl_wr,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [23:0]       ctrl_wdat,
  output logic              pkt_done,
  output logic              pkt_err
);

  localparam int DEPTH = CHAINED * 128;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_ADDR_HI,
    S_ADDR_LO,
    S_PIX_R,
    S_PIX_G,
    S_PIX_B,
    S_DROP
  } state_t;

  state_t            state_q;
  logic [7:0]        addr_hi_q;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;
  logic              en_q;
  logic [3:0]        wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdat_q;
  logic              done_q;
  logic              err_q;

  logic              xfer_d;
  logic [15:0]       start_d;
  logic              start_ok_d;
  logic [ADDR_W-1:0] ptr_next_d;

  // ready_q is low only while reset is held, so it doubles as the transfer qualifier
  assign xfer_d     = in_valid && ready_q;
  assign start_d    = {addr_hi_q, in_data};
  assign start_ok_d = (32'(start_d) < 32'(DEPTH));
  assign ptr_next_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge ctrl_clk or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      state_q   <= S_ADDR_HI;
      addr_hi_q <= '0;
      r_q       <= '0;
      g_q       <= '0;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      en_q      <= 1'b0;
      wr_q      <= 4'b0000;
      addr_q    <= '0;
      wdat_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      wr_q    <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (xfer_d) begin
        case (state_q)
          S_ADDR_HI: begin
            addr_hi_q <= in_data;
            if (in_last) begin
              err_q   <= 1'b1;
              state_q <= S_ADDR_HI;
            end else begin
              state_q <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            if (!start_ok_d) begin
              err_q   <= 1'b1;
              state_q <= in_last ? S_ADDR_HI : S_DROP;
            end else begin
              ptr_q <= ADDR_W'(start_d);
              if (in_last) begin
                done_q  <= 1'b1;
                state_q <= S_ADDR_HI;
              end else begin
                state_q <= S_PIX_R;
              end
            end
          end
          S_PIX_R: begin
            r_q <= in_data;
            if (in_last) begin
              err_q   <= 1'b1;
              state_q <= S_ADDR_HI;
            end else begin
              state_q <= S_PIX_G;
            end
          end
          S_PIX_G: begin
            g_q <= in_data;
            if (in_last) begin
              err_q   <= 1'b1;
              state_q <= S_ADDR_HI;
            end else begin
              state_q <= S_PIX_B;
            end
          end
          S_PIX_B: begin
            en_q   <= 1'b1;
            wr_q   <= 4'b0111;
            addr_q <= ptr_q;
            wdat_q <= {r_q, g_q, in_data};
            ptr_q  <= ptr_next_d;
            if (in_last) begin
              done_q  <= 1'b1;
              state_q <= S_ADDR_HI;
            end else begin
              state_q <= S_PIX_R;
            end
          end
          S_DROP: begin
            if (in_last) state_q <= S_ADDR_HI;
          end
          default: state_q <= S_ADDR_HI;
        endcase
      end
    end
  end

  assign in_ready  = ready_q;
  assign ctrl_en   = en_q;
  assign ctrl_wr   = wr_q;
  assign ctrl_addr = addr_q;
  assign ctrl_wdat = wdat_q;
  assign pkt_done  = done_q;
  assign pkt_err   = err_q;

endmodule

// File: doc/panel_loader.md
PANEL_LOADER -- requirements
Module: panel_loader

Interface
REQ-001 Parameter CHAINED, default 3, number of chained panels; pixel memory depth DEPTH = CHAINED*128.
REQ-002 Parameter ADDR_W, default 16, width of ctrl_addr.
REQ-003 ctrl_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 ctrl_resetn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  byte-stream data valid.
REQ-006 in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready on a rising edge.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_last  input  1  marks the final byte of a packet.
REQ-009 ctrl_en  output  1  pixel write strobe, one cycle per pixel.
REQ-010 ctrl_wr  output  4  color-plane write enables; 4'b0111 when ctrl_en, else 4'b0000.
REQ-011 ctrl_addr  output  ADDR_W  pixel address.
REQ-012 ctrl_wdat  output  24  pixel data {R,G,B}.
REQ-013 pkt_done  output  1  one-cycle pulse on a well-formed packet end.
REQ-014 pkt_err  output  1  one-cycle pulse on a malformed packet.

Function
REQ-015 Packet format SHALL be: ADDR_HI, ADDR_LO (start address, big-endian), then zero or more R,G,B byte triples.
REQ-016 FSM states SHALL be ADDR_HI, ADDR_LO, PIX_R, PIX_G, PIX_B, DROP; the FSM advances only on a byte transfer.
REQ-017 Transitions: ADDR_HI->ADDR_LO; ADDR_LO->PIX_R; PIX_R->PIX_G; PIX_G->PIX_B; PIX_B->PIX_R; any state->ADDR_HI on a transfer with in_last, except as given in REQ-022/023.
REQ-018 Start address {ADDR_HI,ADDR_LO} >= DEPTH SHALL pulse pkt_err and enter DROP (or ADDR_HI if in_last is set on that byte).
REQ-019 DROP SHALL discard bytes until the in_last transfer, then return to ADDR_HI with no further pulse.
REQ-020 Transfer in PIX_B SHALL assert ctrl_en, ctrl_wr=0111, ctrl_addr=current pointer, ctrl_wdat={R,G,B} in the next cycle, for exactly one cycle.
REQ-021 Pointer SHALL load the start address in ADDR_LO and increment after each write, wrapping from DEPTH-1 to 0.
REQ-022 in_last on a PIX_B transfer, or on an ADDR_LO transfer with a valid address (zero-pixel packet), SHALL pulse pkt_done one cycle after that transfer (coincident with the final ctrl_en, if any).
REQ-023 in_last on an ADDR_HI, PIX_R or PIX_G transfer SHALL pulse pkt_err; any partial triple is not written; next state ADDR_HI.
REQ-024 in_ready SHALL be 1 in every state from the first clock after reset release; the block never backpressures.
REQ-025 ctrl_addr and ctrl_wdat SHALL be registered and hold their last values when ctrl_en is 0.
REQ-026 in_data/in_last SHALL be ignored when in_valid is 0 or in_ready is 0.

Reset
REQ-027 While ctrl_resetn is 0: state=ADDR_HI, pointer=0, in_ready=0, ctrl_en=0, ctrl_wr=0, ctrl_addr=0, ctrl_wdat=0, pkt_done=0, pkt_err=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet immediately, with no write and no pulse; after release, the next byte is treated as ADDR_HI.

Verification
REQ-029 Bytes 00,05,11,22,33,44,55,66(last) -> writes addr 5 data 112233 and addr 6 data 445566; pkt_done pulses with the second write.
REQ-030 CHAINED=3, start 017F followed by two triples -> writes to addr 383, then addr 0 (wrap).
REQ-031 Start address 0180 (=DEPTH) followed by 6 bytes, last on the final byte -> one pkt_err pulse after ADDR_LO, no ctrl_en; the next packet is accepted normally.
REQ-032 Bytes 00,00,AA,BB(last) -> pkt_err pulse, no ctrl_en, state returns to ADDR_HI.
REQ-033 Random in_valid gaps during the pixel phase -> writes identical to the gap-free run; ctrl_en never exceeds one cycle per triple.
REQ-034 ctrl_resetn pulled low after ADDR_LO and an R byte -> all outputs go to reset values; after release, packet 00,01,01,02,03(last) writes 010203 at addr 1.
